mem_responder: RTL
==================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter MEM_AW, default 10: word-address width of the internal 32-bit memory (2^MEM_AW words).
REQ-002 Parameter BASE, default 32'h0: first bus address decoded by this block.
REQ-003 Parameter LATENCY, default 2, legal range 1..15: number of ACCESS cycles per transaction.
REQ-004 clk  input  1  clock; all logic on the rising edge.
REQ-005 rst  input  1  reset, synchronous, active-high.
REQ-006 read_q  input  1  read request strobe; only a sampled value of 1 counts, X/Z is ignored.
REQ-007 write_q  input  1  write request strobe; same sampling rule as read_q.
REQ-008 addr_in  input  32  request address, sampled with read_q/write_q.
REQ-009 data_in  input  32  write data, sampled with write_q.
REQ-010 read_e  input  1  initiator acknowledge that ends a read response.
REQ-011 write_e  input  1  initiator acknowledge that ends a write response.
REQ-012 is_bus_busy  output  1  high while a transaction is in ACCESS or RESP.
REQ-013 addr_out / addr_oe  output  32 / 1  echoed transaction address, and its drive enable for the shared addr bus.
REQ-014 data_out / data_oe  output  32 / 1  read data, and its drive enable for the shared data bus.
REQ-015 read_dn / write_dn  output  1 each  response-valid flags.
REQ-016 ovf  output  1  sticky flag: a request was dropped.
REQ-017 tmo  output  1  sticky flag: a response was abandoned because no acknowledge arrived.

Function
REQ-018 Request queue: 2-entry FIFO; each entry is {is_write, addr, data}; requests are captured on any edge where a strobe is sampled as 1.
REQ-019 read_q and write_q both 1 on the same edge: the write is enqueued first, then the read; if only one slot is free, the write is taken, the read is dropped and ovf is set.
REQ-020 FIFO full: the incoming request is dropped and ovf is set, except when the FSM pops on the same edge; then the request is accepted.
REQ-021 Decode: word index = (addr - BASE)[MEM_AW-1:0].
REQ-022 Out of range (addr < BASE or addr >= BASE + 2^MEM_AW): a read returns 32'h0 and a write is discarded; the handshake still completes normally.
REQ-023 FSM states: IDLE, ACCESS, RESP.
REQ-024 IDLE: if the FIFO is non-empty, pop the head, load cnt = LATENCY, set is_bus_busy = 1, go to ACCESS.
REQ-025 ACCESS: decrement cnt each cycle; on the edge where cnt = 1, go to RESP; a write is committed to memory on that same edge.
REQ-026 RESP, read: read_dn = 1, addr_out = request address, data_out = memory word, addr_oe = 1, data_oe = 1.
REQ-027 RESP, write: write_dn = 1, addr_out = request address, addr_oe = 1, data_oe = 0.
REQ-028 RESP outputs hold stable until the matching acknowledge (read_e for reads, write_e for writes) is sampled as 1; the non-matching acknowledge is ignored.
REQ-029 On the acknowledge edge: all response outputs and is_bus_busy go to 0 and the FSM returns to IDLE; the next FIFO entry is popped no earlier than the following edge.
REQ-030 Timeout: after 255 cycles in RESP without an acknowledge, set tmo and return to IDLE; a write already committed stays committed.
REQ-031 Latency: request sampled at edge E0 -> is_bus_busy = 1 after E1 -> read_dn/write_dn = 1 after E(1+LATENCY).
REQ-032 Read data reflects every write committed before this read's RESP entry, including a write queued immediately ahead of it.
REQ-033 All outputs are registered; there is no combinational path from inputs to outputs.

Reset
REQ-034 While rst = 1: FIFO emptied, FSM to IDLE, cnt = 0, all outputs = 0, ovf = 0, tmo = 0.
REQ-035 Memory contents are not cleared by reset.
REQ-036 rst asserted mid-transaction: the transaction is abandoned with no memory write unless the write was already committed; response outputs = 0 on the next edge.

Verification
REQ-037 Write 0x12345678 to BASE+4, write_e after write_dn, then read BASE+4, read_e after read_dn -> read_dn with data_out = 0x12345678 and addr_out = BASE+4, 3 edges after read_q (LATENCY = 2).
REQ-038 read_q and write_q in the same cycle at addr BASE+8 with data 0xA5A5A5A5, FIFO empty -> the write is serviced first, then the read returns 0xA5A5A5A5; ovf = 0.
REQ-039 Three reads on consecutive cycles while busy -> the first two are serviced in order, the third is dropped; ovf = 1 and stays 1 until rst.
REQ-040 Read at BASE + 2^MEM_AW -> data_out = 0, read_dn = 1; a write to that address leaves memory unchanged.
REQ-041 Read with read_e withheld -> read_dn held for 255 cycles, then 0; tmo = 1; the next queued request is then serviced.
REQ-042 rst pulsed during ACCESS of a write to BASE+0 that holds 0x11 -> outputs = 0, ovf = 0 and tmo = 0, and a following read of BASE+0 returns 0x11.

Source files
------------

// File: rtl/mem_responder_if.sv
// Request/response bus between an initiator and mem_responder.
// The slave modport is the responder view; master is the initiator view.
interface mem_responder_if;
  logic        read_q;
  logic        write_q;
  logic [31:0] addr_in;
  logic [31:0] data_in;
  logic        read_e;
  logic        write_e;
  logic        is_bus_busy;
  logic [31:0] addr_out;
  logic        addr_oe;
  logic [31:0] data_out;
  logic        data_oe;
  logic        read_dn;
  logic        write_dn;
  logic        ovf;
  logic        tmo;

  modport slave (
    input  read_q, write_q, addr_in, data_in, read_e, write_e,
    output is_bus_busy, addr_out, addr_oe, data_out, data_oe,
           read_dn, write_dn, ovf, tmo
  );

  modport master (
    output read_q, write_q, addr_in, data_in, read_e, write_e,
    input  is_bus_busy, addr_out, addr_oe, data_out, data_oe,
           read_dn, write_dn, ovf, tmo
  );
endinterface

// File: rtl/mem_responder.sv
// 32-bit word memory behind a 2-deep request queue; response LATENCY+1 edges after the strobe.
// A full queue drops requests (sticky ovf); a response unacknowledged for 255 cycles is abandoned (sticky tmo).
module mem_responder #(
  parameter int          MEM_AW  = 10,
  parameter logic [31:0] BASE    = 32'h0,
  parameter int          LATENCY = 2
) (
  input logic            clk,
  input logic            rst,
  mem_responder_if.slave bus
);

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [31:0] data;
  } req_t;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  localparam int TMO_CYCLES = 255;

  state_t      r_state;
  state_t      w_state_nxt;

  req_t        r_fifo [2];
  req_t        w_fifo_nxt [2];
  logic [1:0]  r_count;
  logic [1:0]  w_count_nxt;

  req_t        r_cur;
  req_t        w_cur_nxt;
  logic [3:0]  r_cnt;
  logic [3:0]  w_cnt_nxt;
  logic [7:0]  r_tmo_cnt;
  logic [7:0]  w_tmo_cnt_nxt;

  logic [31:0] r_mem [2**MEM_AW];

  logic        r_busy;
  logic        r_read_dn;
  logic        r_write_dn;
  logic [31:0] r_addr_out;
  logic        r_addr_oe;
  logic [31:0] r_data_out;
  logic        r_data_oe;
  logic        r_ovf;
  logic        r_tmo;

  logic        w_busy_nxt;
  logic        w_read_dn_nxt;
  logic        w_write_dn_nxt;
  logic [31:0] w_addr_out_nxt;
  logic        w_addr_oe_nxt;
  logic [31:0] w_data_out_nxt;
  logic        w_data_oe_nxt;

  logic        w_rd_req;
  logic        w_wr_req;
  logic        w_pop;
  logic        w_drop;
  logic        w_ack;
  logic        w_tmo_set;
  logic        w_commit;

  logic [31:0]       w_off;
  logic              w_in_range;
  logic [MEM_AW-1:0] w_idx;
  logic [31:0]       w_rd_word;

  // Strobes and acks count only when sampled as a clean 1; X/Z never starts or ends a transaction.
  assign w_rd_req = (bus.read_q  === 1'b1);
  assign w_wr_req = (bus.write_q === 1'b1);
  assign w_ack    = r_cur.is_write ? (bus.write_e === 1'b1) : (bus.read_e === 1'b1);

  assign w_off      = r_cur.addr - BASE;
  assign w_in_range = (r_cur.addr >= BASE) && ((w_off >> MEM_AW) == 32'd0);
  assign w_idx      = w_off[MEM_AW-1:0];
  assign w_rd_word  = w_in_range ? r_mem[w_idx] : 32'h0;

  assign w_commit = !rst && (r_state == ACCESS) && (r_cnt == 4'd1)
                    && r_cur.is_write && w_in_range;

  // Queue update: the pop frees its slot before this edge's pushes; a write outranks a simultaneous read.
  always_comb begin
    w_fifo_nxt  = r_fifo;
    w_count_nxt = r_count;
    w_drop      = 1'b0;

    if (w_pop) begin
      w_fifo_nxt[0] = r_fifo[1];
      w_count_nxt   = r_count - 2'd1;
    end

    if (w_wr_req) begin
      if (w_count_nxt < 2'd2) begin
        w_fifo_nxt[w_count_nxt[0]] = {1'b1, bus.addr_in, bus.data_in};
        w_count_nxt                = w_count_nxt + 2'd1;
      end else begin
        w_drop = 1'b1;
      end
    end

    if (w_rd_req) begin
      if (w_count_nxt < 2'd2) begin
        w_fifo_nxt[w_count_nxt[0]] = {1'b0, bus.addr_in, 32'h0};
        w_count_nxt                = w_count_nxt + 2'd1;
      end else begin
        w_drop = 1'b1;
      end
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cur_nxt      = r_cur;
    w_cnt_nxt      = r_cnt;
    w_tmo_cnt_nxt  = r_tmo_cnt;
    w_pop          = 1'b0;
    w_tmo_set      = 1'b0;
    w_busy_nxt     = r_busy;
    w_read_dn_nxt  = r_read_dn;
    w_write_dn_nxt = r_write_dn;
    w_addr_out_nxt = r_addr_out;
    w_addr_oe_nxt  = r_addr_oe;
    w_data_out_nxt = r_data_out;
    w_data_oe_nxt  = r_data_oe;

    unique case (r_state)
      IDLE: begin
        if (r_count != 2'd0) begin
          w_pop       = 1'b1;
          w_cur_nxt   = r_fifo[0];
          w_cnt_nxt   = 4'(LATENCY);
          w_busy_nxt  = 1'b1;
          w_state_nxt = ACCESS;
        end
      end

      ACCESS: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if (r_cnt == 4'd1) begin
          w_state_nxt    = RESP;
          w_tmo_cnt_nxt  = 8'd0;
          w_addr_out_nxt = r_cur.addr;
          w_addr_oe_nxt  = 1'b1;
          if (r_cur.is_write) begin
            w_write_dn_nxt = 1'b1;
          end else begin
            w_read_dn_nxt  = 1'b1;
            w_data_out_nxt = w_rd_word;
            w_data_oe_nxt  = 1'b1;
          end
        end
      end

      RESP: begin
        // An acknowledge on the final timeout cycle still counts as a clean completion.
        if (w_ack || (r_tmo_cnt == 8'(TMO_CYCLES - 1))) begin
          w_tmo_set      = !w_ack;
          w_state_nxt    = IDLE;
          w_busy_nxt     = 1'b0;
          w_read_dn_nxt  = 1'b0;
          w_write_dn_nxt = 1'b0;
          w_addr_out_nxt = 32'h0;
          w_addr_oe_nxt  = 1'b0;
          w_data_out_nxt = 32'h0;
          w_data_oe_nxt  = 1'b0;
        end else begin
          w_tmo_cnt_nxt = r_tmo_cnt + 8'd1;
        end
      end

      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fifo[0]  <= '0;
      r_fifo[1]  <= '0;
      r_count    <= 2'd0;
      r_cur      <= '0;
      r_cnt      <= 4'd0;
      r_tmo_cnt  <= 8'd0;
      r_busy     <= 1'b0;
      r_read_dn  <= 1'b0;
      r_write_dn <= 1'b0;
      r_addr_out <= 32'h0;
      r_addr_oe  <= 1'b0;
      r_data_out <= 32'h0;
      r_data_oe  <= 1'b0;
      r_ovf      <= 1'b0;
      r_tmo      <= 1'b0;
    end else begin
      r_fifo     <= w_fifo_nxt;
      r_count    <= w_count_nxt;
      r_cur      <= w_cur_nxt;
      r_cnt      <= w_cnt_nxt;
      r_tmo_cnt  <= w_tmo_cnt_nxt;
      r_busy     <= w_busy_nxt;
      r_read_dn  <= w_read_dn_nxt;
      r_write_dn <= w_write_dn_nxt;
      r_addr_out <= w_addr_out_nxt;
      r_addr_oe  <= w_addr_oe_nxt;
      r_data_out <= w_data_out_nxt;
      r_data_oe  <= w_data_oe_nxt;
      r_ovf      <= r_ovf | w_drop;
      r_tmo      <= r_tmo | w_tmo_set;
    end
  end

  // Memory survives reset; only the commit gate sees rst, so an interrupted write never lands.
  always_ff @(posedge clk) begin
    if (w_commit) r_mem[w_idx] <= r_cur.data;
  end

  assign bus.is_bus_busy = r_busy;
  assign bus.read_dn     = r_read_dn;
  assign bus.write_dn    = r_write_dn;
  assign bus.addr_out    = r_addr_out;
  assign bus.addr_oe     = r_addr_oe;
  assign bus.data_out    = r_data_out;
  assign bus.data_oe     = r_data_oe;
  assign bus.ovf         = r_ovf;
  assign bus.tmo         = r_tmo;

endmodule
